// File: rtl/crc_sched_pkg.sv
// Shared types for the CRC frame scheduler and the CRC engine it drives.
package crc_sched_pkg;

  typedef enum logic [1:0] {
    CRC_NONE  = 2'd0,
    CRC_INIT  = 2'd1,
    CRC_DATA  = 2'd2,
    CRC_CHECK = 2'd3
  } crc_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_DATA,
    ST_CHECK,
    ST_WAIT_RES,
    ST_RESP
  } sched_state_e;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found      = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
  end

endmodule

// File: rtl/crc_frame_scheduler.sv
// Time-shares one CRC engine between N_REQ frame requesters, sequencing
// INIT/DATA/CHECK per frame and routing the verdict back to the owner.
module crc_frame_scheduler
  import crc_sched_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*CNT_W-1:0]  req_count,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        dat_valid,
  input  logic [N_REQ*DATA_W-1:0] dat_data,
  output logic [N_REQ-1:0]        dat_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [N_REQ-1:0]        rsp_ok,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic                    cmd_valid,
  output logic [1:0]              cmd_op,
  output logic [DATA_W-1:0]       cmd_data,
  input  logic                    cmd_ready,
  input  logic                    eng_valid,
  input  logic                    eng_ok,
  output logic                    eng_ready,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant,
  output logic [7:0]              err_cnt
);

  sched_state_e      state, state_d;
  logic [IDX_W-1:0]  rr, rr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0]  remaining, remaining_d;
  logic              verdict, verdict_d;
  logic [7:0]        err_q, err_d;
  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic [N_REQ-1:0]  gnt_oh;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  crc_op_e           op;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign gnt_oh    = N_REQ'(1) << grant_q;
  assign sel_valid = dat_valid[grant_q];
  assign sel_data  = dat_data[int'(grant_q)*DATA_W +: DATA_W];

  assign cmd_op  = op;
  assign busy    = (state != ST_IDLE);
  assign grant   = grant_q;
  assign err_cnt = err_q;

  // Outputs are held low while rst_n is asserted, even if requests are pending.
  always_comb begin
    state_d     = state;
    rr_d        = rr;
    grant_d     = grant_q;
    remaining_d = remaining;
    verdict_d   = verdict;
    err_d       = err_q;
    req_ready   = '0;
    dat_ready   = '0;
    rsp_valid   = '0;
    rsp_ok      = '0;
    cmd_valid   = 1'b0;
    op          = CRC_NONE;
    cmd_data    = '0;
    eng_ready   = 1'b0;

    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            req_ready   = arb_gnt;
            grant_d     = arb_idx;
            remaining_d = req_count[int'(arb_idx)*CNT_W +: CNT_W];
            state_d     = ST_INIT;
          end
        end
        ST_INIT: begin
          cmd_valid = 1'b1;
          op        = CRC_INIT;
          if (cmd_ready) state_d = (remaining != '0) ? ST_DATA : ST_CHECK;
        end
        ST_DATA: begin
          cmd_valid = sel_valid;
          op        = CRC_DATA;
          cmd_data  = sel_data;
          dat_ready = gnt_oh & {N_REQ{cmd_ready}};
          if (sel_valid && cmd_ready) begin
            remaining_d = remaining - 1'b1;
            if (remaining == CNT_W'(1)) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          cmd_valid = sel_valid;
          op        = CRC_CHECK;
          cmd_data  = sel_data;
          dat_ready = gnt_oh & {N_REQ{cmd_ready}};
          if (sel_valid && cmd_ready) state_d = ST_WAIT_RES;
        end
        ST_WAIT_RES: begin
          eng_ready = 1'b1;
          if (eng_valid) begin
            verdict_d = eng_ok;
            if (!eng_ok && err_q != ERR_CNT_MAX) err_d = err_q + 8'd1;
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid = gnt_oh;
          rsp_ok    = verdict ? gnt_oh : '0;
          if (rsp_ready[grant_q]) begin
            rr_d    = (grant_q == IDX_W'(N_REQ-1)) ? '0 : grant_q + 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr        <= '0;
      grant_q   <= '0;
      remaining <= '0;
      verdict   <= 1'b0;
      err_q     <= '0;
    end else begin
      state     <= state_d;
      rr        <= rr_d;
      grant_q   <= grant_d;
      remaining <= remaining_d;
      verdict   <= verdict_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_crc_frame_scheduler.sv
// Scoreboard bench for crc_frame_scheduler: requester/engine models drive the
// DUT, expected commands, grants and verdicts are queued as frames are posted.
module tb_crc_frame_scheduler;
  import crc_sched_pkg::*;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid, req_ready, dat_valid, dat_ready;
  logic [N-1:0]  rsp_valid, rsp_ok, rsp_ready;
  logic [N*CW-1:0] req_count;
  logic [N*DW-1:0] dat_data;
  logic          cmd_valid, cmd_ready, eng_valid, eng_ok, eng_ready, busy;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic [0:0]    grant;
  logic [7:0]    err_cnt;

  crc_frame_scheduler #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_count(req_count), .req_ready(req_ready),
    .dat_valid(dat_valid), .dat_data(dat_data), .dat_ready(dat_ready),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_ready(rsp_ready),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .eng_valid(eng_valid), .eng_ok(eng_ok), .eng_ready(eng_ready),
    .busy(busy), .grant(grant), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] cnt0_q[$], cnt1_q[$], feed0_q[$], feed1_q[$];
  logic [9:0] exp_cmd_q[$];
  logic [1:0] exp_rsp_q[$];
  logic       exp_grant_q[$];
  logic       verd_q[$];

  int tests = 0;
  int fails = 0;
  int consumed[N];
  int exp_err = 0;
  int chk_req = 0, chk_ack = 0, take_req = 0, take_ack = 0;
  bit bp_mode = 0, gap_mode = 0;
  bit hold_valid = 0;
  logic [9:0] hold_cmd;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  // Posts one frame: requester-side data plus every expectation it implies.
  task automatic applyStimulus(input int r, input int count, input logic [7:0] first,
                               input logic [7:0] step, input logic [7:0] chk, input logic ok);
    logic [7:0] b;
    b = first;
    exp_grant_q.push_back(r[0]);
    exp_cmd_q.push_back({2'd1, 8'h00});
    if (r == 0) cnt0_q.push_back(count[7:0]);
    else        cnt1_q.push_back(count[7:0]);
    for (int i = 0; i < count; i++) begin
      if (r == 0) feed0_q.push_back(b);
      else        feed1_q.push_back(b);
      exp_cmd_q.push_back({2'd2, b});
      b = b + step;
    end
    if (r == 0) feed0_q.push_back(chk);
    else        feed1_q.push_back(chk);
    exp_cmd_q.push_back({2'd3, chk});
    verd_q.push_back(ok);
    exp_rsp_q.push_back({r[0], ok});
    if (!ok && exp_err < 255) exp_err++;
  endtask

  task automatic waitDone(input int max_cycles);
    for (int i = 0; i < max_cycles && (exp_rsp_q.size() != 0 || busy); i++) stepCycle();
    checkOutput("frame_done", exp_rsp_q.size(), 0);
    checkOutput("cmds_done", exp_cmd_q.size(), 0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 0);
    checkOutput({tag, "_dat_ready"}, dat_ready, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_rsp_ok"}, rsp_ok, 0);
    checkOutput({tag, "_cmd_valid"}, cmd_valid, 0);
    checkOutput({tag, "_cmd_op"}, cmd_op, 0);
    checkOutput({tag, "_cmd_data"}, cmd_data, 0);
    checkOutput({tag, "_eng_ready"}, eng_ready, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_grant"}, grant, 0);
    checkOutput({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  // Monitor: observes handshakes at the falling edge, ahead of the rising edge that commits them.
  always @(negedge clk) begin
    logic [1:0] g_oh;
    if (!rst_n) begin
      hold_valid = 0;
    end else begin
      g_oh = 2'b01 << grant;
      if (hold_valid && cmd_valid) checkOutput("cmd_hold", {cmd_op, cmd_data}, hold_cmd);
      hold_valid = cmd_valid && !cmd_ready;
      hold_cmd   = {cmd_op, cmd_data};
      if (cmd_valid && cmd_ready) begin
        checkOutput("cmd", {cmd_op, cmd_data},
                    exp_cmd_q.size() != 0 ? {22'd0, exp_cmd_q.pop_front()} : 32'hDEAD);
        if (cmd_op == 2'd3) chk_req++;
      end
      if (dat_valid[0] && dat_ready[0]) begin consumed[0]++; if (feed0_q.size() != 0) void'(feed0_q.pop_front()); end
      if (dat_valid[1] && dat_ready[1]) begin consumed[1]++; if (feed1_q.size() != 0) void'(feed1_q.pop_front()); end
      if (|req_ready) checkOutput("req_ready_onehot", req_ready & (req_ready - 2'd1), 0);
      for (int k = 0; k < N; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          if (k == 0 && cnt0_q.size() != 0) void'(cnt0_q.pop_front());
          if (k == 1 && cnt1_q.size() != 0) void'(cnt1_q.pop_front());
          checkOutput("grant", k, exp_grant_q.size() != 0 ? {31'd0, exp_grant_q.pop_front()} : 32'hDEAD);
        end
        if (rsp_valid[k] && rsp_ready[k])
          checkOutput("rsp", {k[0], rsp_ok[k]},
                      exp_rsp_q.size() != 0 ? {30'd0, exp_rsp_q.pop_front()} : 32'hDEAD);
      end
      if (busy) begin
        checkOutput("dat_ready_excl", dat_ready & ~g_oh, 0);
        checkOutput("rsp_valid_excl", rsp_valid & ~g_oh, 0);
      end
      if (eng_valid && eng_ready) take_req++;
    end
  end

  // Requester and engine models drive just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      req_valid = '0; req_count = '0; dat_valid = '0; dat_data = '0;
      cmd_ready = 1'b0; rsp_ready = '0; eng_valid = 1'b0; eng_ok = 1'b0;
      chk_ack = chk_req; take_ack = take_req;
    end else begin
      req_valid[0]   = cnt0_q.size() != 0;
      req_count[7:0] = cnt0_q.size() != 0 ? cnt0_q[0] : 8'h00;
      req_valid[1]   = cnt1_q.size() != 0;
      req_count[15:8] = cnt1_q.size() != 0 ? cnt1_q[0] : 8'h00;
      dat_valid[0]   = feed0_q.size() != 0 && (!gap_mode || $urandom_range(0, 3) != 0);
      dat_data[7:0]  = feed0_q.size() != 0 ? feed0_q[0] : 8'h00;
      dat_valid[1]   = feed1_q.size() != 0 && (!gap_mode || $urandom_range(0, 3) != 0);
      dat_data[15:8] = feed1_q.size() != 0 ? feed1_q[0] : 8'h00;
      cmd_ready = bp_mode ? ~cmd_ready : 1'b1;
      rsp_ready = bp_mode ? ~rsp_ready : '1;
      if (take_ack != take_req) begin eng_valid = 1'b0; take_ack = take_req; end
      if (chk_ack != chk_req) begin
        eng_valid = 1'b1;
        eng_ok    = verd_q.size() != 0 ? verd_q.pop_front() : 1'b0;
        chk_ack   = chk_req;
      end
    end
  end

  initial begin
    int c;
    req_valid = '0; req_count = '0; dat_valid = '0; dat_data = '0;
    cmd_ready = 1'b0; rsp_ready = '0; eng_valid = 1'b0; eng_ok = 1'b0;
    consumed[0] = 0; consumed[1] = 0;
    repeat (3) @(posedge clk);
    #2;
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    stepCycle();

    $display("[TB] single frame");
    applyStimulus(0, 3, 8'h11, 8'h11, 8'hA5, 1'b1);
    waitDone(200);
    checkOutput("err_after_single", err_cnt, 0);

    $display("[TB] zero-length frame");
    c = consumed[1];
    applyStimulus(1, 0, 8'h00, 8'h00, 8'h5A, 1'b1);
    waitDone(200);
    checkOutput("zero_len_bytes", consumed[1] - c, 1);

    $display("[TB] contention");
    applyStimulus(0, 2, 8'h30, 8'h01, 8'hC0, 1'b1);
    applyStimulus(1, 3, 8'h40, 8'h01, 8'hC1, 1'b1);
    applyStimulus(0, 1, 8'h50, 8'h01, 8'hC2, 1'b1);
    applyStimulus(1, 2, 8'h60, 8'h01, 8'hC3, 1'b1);
    waitDone(400);

    $display("[TB] backpressure");
    bp_mode = 1; gap_mode = 1;
    applyStimulus(0, 6, 8'h70, 8'h03, 8'h99, 1'b1);
    applyStimulus(1, 5, 8'h90, 8'h07, 8'h77, 1'b1);
    waitDone(600);
    bp_mode = 0; gap_mode = 0;
    checkOutput("feeds_drained", feed0_q.size() + feed1_q.size(), 0);

    $display("[TB] failure counting");
    for (int i = 0; i < 260; i++) begin
      applyStimulus((i + 1) % 2, i % 3, 8'(i), 8'h01, 8'(i ^ 8'h3C), 1'b0);
      waitDone(100);
      checkOutput("err_cnt", err_cnt, exp_err);
    end

    $display("[TB] reset mid-frame");
    c = consumed[1];
    applyStimulus(1, 10, 8'h80, 8'h01, 8'hEE, 1'b1);
    for (int i = 0; i < 100 && (consumed[1] - c) < 4; i++) stepCycle();
    checkOutput("reached_data", consumed[1] - c, 4);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("reset_mid");
    cnt0_q.delete(); cnt1_q.delete(); feed0_q.delete(); feed1_q.delete();
    exp_cmd_q.delete(); exp_rsp_q.delete(); exp_grant_q.delete(); verd_q.delete();
    exp_err = 0;
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    checkOutput("post_reset_busy", busy, 0);
    applyStimulus(0, 2, 8'h01, 8'h01, 8'h10, 1'b1);
    applyStimulus(1, 1, 8'h02, 8'h01, 8'h20, 1'b1);
    waitDone(300);
    checkOutput("post_reset_err", err_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
